// File: rtl/vx_fetch_unit.sv
// Fetch stage between the warp scheduler and decode: issues I-cache word fetches tagged by warp id,
// parks per-warp metadata until the response returns, and queues fetched instructions for decode.
module vx_fetch_unit #(
   parameter int NUM_WARPS    = 4,
   parameter int NUM_THREADS  = 4,
   parameter int XLEN         = 32,
   parameter int UUID_WIDTH   = 44,
   parameter int OUT_BUF_SIZE = 2,
   localparam int NW_WIDTH    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   sched_valid,
   output logic                   sched_ready,
   input  logic [NW_WIDTH-1:0]    sched_wid,
   input  logic [NUM_THREADS-1:0] sched_tmask,
   input  logic [XLEN-1:0]        sched_pc,
   input  logic [UUID_WIDTH-1:0]  sched_uuid,
   output logic                   icache_req_valid,
   input  logic                   icache_req_ready,
   output logic [XLEN-3:0]        icache_req_addr,
   output logic [NW_WIDTH-1:0]    icache_req_tag,
   input  logic                   icache_rsp_valid,
   output logic                   icache_rsp_ready,
   input  logic [31:0]            icache_rsp_data,
   input  logic [NW_WIDTH-1:0]    icache_rsp_tag,
   output logic                   fetch_valid,
   input  logic                   fetch_ready,
   output logic [NW_WIDTH-1:0]    fetch_wid,
   output logic [NUM_THREADS-1:0] fetch_tmask,
   output logic [XLEN-1:0]        fetch_pc,
   output logic [31:0]            fetch_instr,
   output logic [UUID_WIDTH-1:0]  fetch_uuid,
   output logic [NUM_WARPS-1:0]   pending_warps,
   output logic                   busy
);

   localparam int META_W  = NUM_THREADS + XLEN + UUID_WIDTH;
   localparam int ENTRY_W = NW_WIDTH + 32 + META_W;
   localparam int PTR_W   = (OUT_BUF_SIZE > 1) ? $clog2(OUT_BUF_SIZE) : 1;
   localparam int CNT_W   = $clog2(OUT_BUF_SIZE + 1);

   logic [NUM_WARPS-1:0] pending;
   logic [META_W-1:0]    tag_store [NUM_WARPS];
   logic [ENTRY_W-1:0]   buf_mem [OUT_BUF_SIZE];
   logic [PTR_W-1:0]     wr_ptr, rd_ptr;
   logic [CNT_W-1:0]     count;

   logic                 warp_free, req_fire, rsp_fire, out_fire, buf_ready;
   logic [NUM_WARPS-1:0] set_mask, clr_mask;
   logic [META_W-1:0]    rsp_meta;
   logic [ENTRY_W-1:0]   rsp_entry;

   // Request path is purely combinational; a warp with a fetch in flight is held back.
   assign warp_free        = ~pending[sched_wid];
   assign icache_req_valid = sched_valid & warp_free;
   assign sched_ready      = icache_req_ready & warp_free;
   assign icache_req_addr  = sched_pc[XLEN-1:2];
   assign icache_req_tag   = sched_wid;
   assign req_fire         = sched_valid & sched_ready;

   assign buf_ready        = (count != CNT_W'(OUT_BUF_SIZE));
   assign icache_rsp_ready = buf_ready;
   assign rsp_fire         = icache_rsp_valid & buf_ready;
   assign fetch_valid      = (count != '0);
   assign out_fire         = fetch_valid & fetch_ready;

   assign rsp_meta  = tag_store[icache_rsp_tag];
   assign rsp_entry = {icache_rsp_tag, icache_rsp_data, rsp_meta};
   assign {fetch_wid, fetch_instr, fetch_tmask, fetch_pc, fetch_uuid} = buf_mem[rd_ptr];

   assign set_mask = req_fire ? (NUM_WARPS'(1) << sched_wid) : '0;
   assign clr_mask = rsp_fire ? (NUM_WARPS'(1) << icache_rsp_tag) : '0;

   assign pending_warps = pending;
   assign busy          = (|pending) | fetch_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
      end else begin
         pending <= (pending | set_mask) & ~clr_mask;
         if (rsp_fire)
            wr_ptr <= (wr_ptr == PTR_W'(OUT_BUF_SIZE - 1)) ? '0 : wr_ptr + 1'b1;
         if (out_fire)
            rd_ptr <= (rd_ptr == PTR_W'(OUT_BUF_SIZE - 1)) ? '0 : rd_ptr + 1'b1;
         count <= count + CNT_W'(rsp_fire) - CNT_W'(out_fire);
      end
   end

   // Metadata and buffered instructions carry no reset; validity lives in pending/count.
   always_ff @(posedge clk) begin
      if (req_fire)
         tag_store[sched_wid] <= {sched_tmask, sched_pc, sched_uuid};
      if (rsp_fire)
         buf_mem[wr_ptr] <= rsp_entry;
   end

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (!reset) begin
         assert (!$isunknown({sched_valid, icache_req_ready, icache_rsp_valid, fetch_ready}))
            else $error("vx_fetch_unit: unknown value on a handshake input");
         if (rsp_fire)
            assert (pending[icache_rsp_tag])
               else $error("vx_fetch_unit: response for warp %0d with no fetch outstanding", icache_rsp_tag);
         if (req_fire)
            assert (sched_pc[1:0] == 2'b00)
               else $error("vx_fetch_unit: misaligned fetch pc %0h", sched_pc);
      end
   end
`endif

endmodule

// File: tb/tb_vx_fetch_unit.sv
// Directed bench for vx_fetch_unit: issue, out-of-order return, decode stall, blocked warp,
// I-cache backpressure and asynchronous reset with fetches in flight.
module tb_vx_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        sched_valid, sched_ready;
   logic [1:0]  sched_wid;
   logic [3:0]  sched_tmask;
   logic [31:0] sched_pc;
   logic [43:0] sched_uuid;
   logic        icache_req_valid, icache_req_ready;
   logic [29:0] icache_req_addr;
   logic [1:0]  icache_req_tag;
   logic        icache_rsp_valid, icache_rsp_ready;
   logic [31:0] icache_rsp_data;
   logic [1:0]  icache_rsp_tag;
   logic        fetch_valid, fetch_ready;
   logic [1:0]  fetch_wid;
   logic [3:0]  fetch_tmask;
   logic [31:0] fetch_pc, fetch_instr;
   logic [43:0] fetch_uuid;
   logic [3:0]  pending_warps;
   logic        busy;

   int total = 0;
   int bad   = 0;

   vx_fetch_unit dut (
      .clk(clk), .reset(reset),
      .sched_valid(sched_valid), .sched_ready(sched_ready), .sched_wid(sched_wid),
      .sched_tmask(sched_tmask), .sched_pc(sched_pc), .sched_uuid(sched_uuid),
      .icache_req_valid(icache_req_valid), .icache_req_ready(icache_req_ready),
      .icache_req_addr(icache_req_addr), .icache_req_tag(icache_req_tag),
      .icache_rsp_valid(icache_rsp_valid), .icache_rsp_ready(icache_rsp_ready),
      .icache_rsp_data(icache_rsp_data), .icache_rsp_tag(icache_rsp_tag),
      .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_wid(fetch_wid),
      .fetch_tmask(fetch_tmask), .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
      .fetch_uuid(fetch_uuid), .pending_warps(pending_warps), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench timed out");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_fetch(input string tag, input logic [1:0] wid, input logic [3:0] tmask,
                            input logic [31:0] pc, input logic [31:0] instr, input logic [43:0] uuid);
      chk({tag, "_valid"}, 64'(fetch_valid), 64'd1);
      chk({tag, "_wid"},   64'(fetch_wid),   64'(wid));
      chk({tag, "_tmask"}, 64'(fetch_tmask), 64'(tmask));
      chk({tag, "_pc"},    64'(fetch_pc),    64'(pc));
      chk({tag, "_instr"}, 64'(fetch_instr), 64'(instr));
      chk({tag, "_uuid"},  64'(fetch_uuid),  64'(uuid));
   endtask

   task automatic issue(input logic [1:0] wid, input logic [3:0] tmask,
                        input logic [31:0] pc, input logic [43:0] uuid);
      sched_valid = 1'b1;
      sched_wid   = wid;
      sched_tmask = tmask;
      sched_pc    = pc;
      sched_uuid  = uuid;
   endtask

   int          idx, nrecv;
   logic        rfire, ofire;
   logic [1:0]  order [3];
   logic [1:0]  w;

   initial begin
      reset = 1'b1;
      sched_valid = 1'b0; sched_wid = '0; sched_tmask = '0; sched_pc = '0; sched_uuid = '0;
      icache_req_ready = 1'b1;
      icache_rsp_valid = 1'b0; icache_rsp_data = '0; icache_rsp_tag = '0;
      fetch_ready = 1'b1;
      repeat (3) tick();
      #1;
      chk("rst_pending", 64'(pending_warps), 64'h0);
      chk("rst_fetch_valid", 64'(fetch_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_req_valid", 64'(icache_req_valid), 64'd0);
      reset = 1'b0;
      tick();

      // single fetch, warp 0
      issue(2'd0, 4'b0001, 32'h8000_0000, 44'h100);
      #1;
      chk("t1_req_valid", 64'(icache_req_valid), 64'd1);
      chk("t1_sched_ready", 64'(sched_ready), 64'd1);
      chk("t1_addr", 64'(icache_req_addr), 64'h2000_0000);
      chk("t1_tag", 64'(icache_req_tag), 64'd0);
      tick();
      sched_valid = 1'b0;
      icache_rsp_valid = 1'b1; icache_rsp_tag = 2'd0; icache_rsp_data = 32'h0000_0013;
      #1;
      chk("t1_pending", 64'(pending_warps), 64'h1);
      chk("t1_rsp_ready", 64'(icache_rsp_ready), 64'd1);
      chk("t1_not_yet", 64'(fetch_valid), 64'd0);
      tick();
      icache_rsp_valid = 1'b0;
      #1;
      chk_fetch("t1_out", 2'd0, 4'b0001, 32'h8000_0000, 32'h13, 44'h100);
      chk("t1_pending_clr", 64'(pending_warps), 64'h0);
      chk("t1_busy", 64'(busy), 64'd1);
      tick();
      #1;
      chk("t1_drained", 64'(fetch_valid), 64'd0);
      chk("t1_idle", 64'(busy), 64'd0);
      tick();

      // warps 1,2,3 issued, returned 3,1,2
      for (int k = 1; k <= 3; k++) begin
         issue(2'(k), 4'(1 << k), 32'(k * 32'h100), 44'(k * 44'h11));
         #1;
         chk("t2_issue", 64'(sched_ready), 64'd1);
         tick();
      end
      sched_valid = 1'b0;
      #1;
      chk("t2_pending", 64'(pending_warps), 64'hE);
      order[0] = 2'd3; order[1] = 2'd1; order[2] = 2'd2;
      for (int i = 0; i < 3; i++) begin
         icache_rsp_valid = 1'b1;
         icache_rsp_tag   = order[i];
         icache_rsp_data  = 32'hAAA0 + 32'(order[i]);
         #1;
         if (i > 0) begin
            w = order[i-1];
            chk_fetch("t2_out", w, 4'(1 << w), 32'(w) * 32'h100, 32'hAAA0 + 32'(w), 44'(w) * 44'h11);
         end
         tick();
      end
      icache_rsp_valid = 1'b0;
      #1;
      chk_fetch("t2_last", 2'd2, 4'b0100, 32'h200, 32'hAAA2, 44'h22);
      tick();
      #1;
      chk("t2_drained", 64'(fetch_valid), 64'd0);
      chk("t2_pending_clr", 64'(pending_warps), 64'h0);
      tick();

      // decode stall with four responses offered
      fetch_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         issue(2'(k), 4'(k + 1), 32'h1000 + 32'(4 * k), 44'h500 + 44'(k));
         tick();
      end
      sched_valid = 1'b0;
      idx = 0;
      for (int c = 0; c < 10; c++) begin
         if (idx < 4) begin
            icache_rsp_valid = 1'b1;
            icache_rsp_tag   = 2'(idx);
            icache_rsp_data  = 32'hC0DE_0000 + 32'(idx);
         end
         #1;
         rfire = icache_rsp_valid & icache_rsp_ready;
         if (c >= 1)
            chk_fetch("t3_stall", 2'd0, 4'd1, 32'h1000, 32'hC0DE_0000, 44'h500);
         tick();
         if (rfire) idx++;
      end
      #1;
      chk("t3_accepted", 64'(idx), 64'd2);
      chk("t3_rsp_blocked", 64'(icache_rsp_ready), 64'd0);
      chk("t3_pending", 64'(pending_warps), 64'hC);
      fetch_ready = 1'b1;
      nrecv = 0;
      for (int c = 0; c < 20; c++) begin
         if (idx < 4) begin
            icache_rsp_valid = 1'b1;
            icache_rsp_tag   = 2'(idx);
            icache_rsp_data  = 32'hC0DE_0000 + 32'(idx);
         end else begin
            icache_rsp_valid = 1'b0;
         end
         #1;
         rfire = icache_rsp_valid & icache_rsp_ready;
         ofire = fetch_valid;
         if (ofire && nrecv < 4)
            chk_fetch("t3_release", 2'(nrecv), 4'(nrecv + 1), 32'h1000 + 32'(4 * nrecv),
                      32'hC0DE_0000 + 32'(nrecv), 44'h500 + 44'(nrecv));
         tick();
         if (rfire) idx++;
         if (ofire) nrecv++;
      end
      #1;
      chk("t3_count", 64'(nrecv), 64'd4);
      chk("t3_pending_clr", 64'(pending_warps), 64'h0);
      tick();

      // request for a warp that already has a fetch in flight
      issue(2'd2, 4'b0100, 32'h2000, 44'h77);
      #1;
      chk("t4_first", 64'(sched_ready), 64'd1);
      tick();
      issue(2'd2, 4'b1111, 32'h3000, 44'h99);
      #1;
      chk("t4_blocked_ready", 64'(sched_ready), 64'd0);
      chk("t4_blocked_req", 64'(icache_req_valid), 64'd0);
      chk("t4_pending", 64'(pending_warps), 64'h4);
      tick();
      sched_valid = 1'b0;
      icache_rsp_valid = 1'b1; icache_rsp_tag = 2'd2; icache_rsp_data = 32'h44;
      #1;
      chk("t4_rsp_ready", 64'(icache_rsp_ready), 64'd1);
      tick();
      icache_rsp_valid = 1'b0;
      #1;
      chk_fetch("t4_out", 2'd2, 4'b0100, 32'h2000, 32'h44, 44'h77);
      tick();

      // I-cache not ready for five cycles
      icache_req_ready = 1'b0;
      issue(2'd1, 4'b0010, 32'h4000, 44'h55);
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("t5_sched_ready", 64'(sched_ready), 64'd0);
         chk("t5_req_valid", 64'(icache_req_valid), 64'd1);
         chk("t5_pending", 64'(pending_warps), 64'h0);
         tick();
      end
      icache_req_ready = 1'b1;
      #1;
      chk("t5_ready_rise", 64'(sched_ready), 64'd1);
      tick();
      sched_valid = 1'b0;
      #1;
      chk("t5_pending_set", 64'(pending_warps), 64'h2);
      icache_rsp_valid = 1'b1; icache_rsp_tag = 2'd1; icache_rsp_data = 32'h55AA;
      tick();
      icache_rsp_valid = 1'b0;
      #1;
      chk_fetch("t5_out", 2'd1, 4'b0010, 32'h4000, 32'h55AA, 44'h55);
      tick();

      // asynchronous reset with work in flight
      fetch_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         issue(2'(k), 4'b1111, 32'h6000 + 32'(4 * k), 44'h600 + 44'(k));
         tick();
      end
      sched_valid = 1'b0;
      icache_rsp_valid = 1'b1; icache_rsp_tag = 2'd0; icache_rsp_data = 32'h66;
      tick();
      icache_rsp_valid = 1'b0;
      #1;
      chk("t6_pre_pending", 64'(pending_warps), 64'h6);
      chk("t6_pre_valid", 64'(fetch_valid), 64'd1);
      #1;
      reset = 1'b1;
      #1;
      chk("t6_pending", 64'(pending_warps), 64'h0);
      chk("t6_fetch_valid", 64'(fetch_valid), 64'd0);
      chk("t6_busy", 64'(busy), 64'd0);
      tick();
      reset = 1'b0;
      fetch_ready = 1'b1;
      tick();
      #1;
      chk("t6_after", 64'(fetch_valid), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
